// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned ENTRY_W = 64;
  localparam int unsigned INSTR_W = ENTRY_W - PC_W;

  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // One prefetch buffer entry: the fetch address and the word read there.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding prefetched {pc, instr} entries.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush empties the FIFO outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only visible while non-empty, so no reset.
  // When full, push and pop share a slot: the popped head is overwritten.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: run/halt FSM, PC sequencing, redirect handling
// and a prefetch buffer towards decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         push, pop;
  logic         buf_full, buf_empty;
  fetch_entry_t wr_entry, head;

  assign wr_entry     = '{pc: pc_q, instr: imem_rdata};
  assign imem_addr    = pc_q;
  assign out_valid    = !buf_empty;
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign busy         = (state_q == ST_RUN);
  assign misalign_err = misalign_q;

  // Next state, PC and buffer strobes; a redirect freezes the FSM and
  // suppresses both push and pop for that cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect) begin
      pc_d = {redirect_target[31:2], 2'b00};
      if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      pop  = !buf_empty && out_ready;
      push = (state_q == ST_RUN) && (!buf_full || pop);
      if (push) pc_d = pc_q + 32'd4;
      unique case (state_q)
        ST_IDLE:   if (start)    state_d = ST_RUN;
        ST_RUN:    if (halt_req) state_d = ST_HALTED;
        ST_HALTED: if (start)    state_d = ST_RUN;
        default:                 state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, PC and sticky misalignment registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random stimulus,
// all compared against a queue-based reference model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        misalign_err;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .halt_req        (halt_req),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .busy            (busy),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words at 0x000..0x0FC, NOP elsewhere.
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    if (addr < 32'h100) return mem[addr[7:2]];
    return NOP_INSTR;
  endfunction

  assign imem_rdata = mem_read(imem_addr);

  // Reference model: FIFO of (pc, instr), a fetch pointer and a mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_HALT = 2;

  ent_t        m_q [$];
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_mis;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Apply one clock edge's worth of input to the model.
  task automatic model_step();
    bit   do_pop, do_push;
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_pc   = 32'h0;
      m_mode = MODE_IDLE;
      m_mis  = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_pc = redirect_target & 32'hFFFF_FFFC;
      if (redirect_target % 4 != 0) m_mis = 1'b1;
    end else begin
      do_pop  = (m_q.size() > 0) && out_ready;
      do_push = (m_mode == MODE_RUN) && (m_q.size() < 2 || do_pop);
      e.pc    = m_pc;
      e.instr = mem_read(m_pc);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == MODE_IDLE && start)      m_mode = MODE_RUN;
      else if (m_mode == MODE_RUN && halt_req) m_mode = MODE_HALT;
      else if (m_mode == MODE_HALT && start)   m_mode = MODE_RUN;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("out_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
    check("out_instr", out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
    check("busy", 32'(busy), 32'(m_mode == MODE_RUN));
    check("imem_addr", imem_addr, m_pc);
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  // Drive inputs just after a falling edge, step the model, then compare
  // at the next falling edge.
  task automatic tick(input logic s, input logic h, input logic r,
                      input logic [31:0] t, input logic rdy, input logic rn);
    start           = s;
    halt_req        = h;
    redirect        = r;
    redirect_target = t;
    out_ready       = rdy;
    rst_n           = rn;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic expect_head(input string tag, input logic v,
                             input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".instr"}, out_instr, instr);
  endtask

  initial begin
    logic [31:0] tgt;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0030_0023;
    for (int i = 4; i < 64; i++) mem[i] = $urandom;

    // Reset state
    tick(0, 0, 0, 32'h0, 1, 0);
    tick(0, 0, 0, 32'h0, 1, 0);
    expect_head("reset", 1'b0, 32'h0, 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.imem_addr", imem_addr, 32'h0);
    check("reset.misalign", 32'(misalign_err), 32'h0);

    // Streaming at full throughput
    tick(1, 0, 0, 32'h0, 1, 1);
    check("stream.busy", 32'(busy), 32'h1);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("stream0", 1'b1, 32'h0, 32'h0050_0093);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("stream1", 1'b1, 32'h4, 32'h00A0_0113);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("stream2", 1'b1, 32'h8, 32'h0020_81B3);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("stream3", 1'b1, 32'hC, 32'h0030_0023);

    // Backpressure: buffer fills with 0 and 4, fetch stalls at 8
    tick(0, 0, 1, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    expect_head("bp.hold", 1'b1, 32'h0, 32'h0050_0093);
    check("bp.imem_addr", imem_addr, 32'h8);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("bp.1", 1'b1, 32'h4, 32'h00A0_0113);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("bp.2", 1'b1, 32'h8, 32'h0020_81B3);

    // Redirect while full
    tick(0, 0, 1, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 1, 32'h8, 0, 1);
    check("redir.flush", 32'(out_valid), 32'h0);
    tick(0, 0, 0, 32'h0, 0, 1); expect_head("redir.head", 1'b1, 32'h8, 32'h0020_81B3);

    // Misaligned redirect
    tick(0, 0, 1, 32'h6, 0, 1);
    check("misalign.flag", 32'(misalign_err), 32'h1);
    tick(0, 0, 0, 32'h0, 0, 1); expect_head("misalign.head", 1'b1, 32'h4, 32'h00A0_0113);

    // Top of memory, out-of-range NOP, and 32-bit PC wrap
    tick(0, 0, 1, 32'hFC, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 1, 1); expect_head("oob", 1'b1, 32'h100, NOP_INSTR);
    tick(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    expect_head("wrap", 1'b1, 32'hFFFF_FFFC, NOP_INSTR);
    check("wrap.imem_addr", imem_addr, 32'h0);

    // Halt with two buffered: drains, no further fetches
    tick(0, 0, 1, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 1, 0, 32'h0, 0, 1);
    check("halt.busy", 32'(busy), 32'h0);
    tick(0, 0, 0, 32'h0, 1, 1);
    tick(0, 0, 0, 32'h0, 1, 1);
    tick(0, 0, 0, 32'h0, 1, 1);
    check("halt.drained", 32'(out_valid), 32'h0);
    check("halt.imem_addr", imem_addr, 32'h8);

    // Reset mid-stream
    tick(1, 0, 0, 32'h0, 1, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 1, 32'h2, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 1);
    tick(0, 0, 0, 32'h0, 0, 0);
    expect_head("rst_mid", 1'b0, 32'h0, 32'h0);
    check("rst_mid.busy", 32'(busy), 32'h0);
    check("rst_mid.misalign", 32'(misalign_err), 32'h0);
    check("rst_mid.imem_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 4 == 0) tgt = $urandom;
      else                   tgt = $urandom_range(0, 32'h11F);
      tick(1'($urandom % 6 == 0), 1'($urandom % 16 == 0), 1'($urandom % 16 == 0),
           tgt, 1'($urandom % 4 != 0), 1'($urandom % 64 != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
